// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller for the MIPS core.
// Sequences FETCH/DECODE/EXEC/MEM_RD/MEM_WR/WB and decodes the per-state
// datapath controls (write enables, mux selects, fetch-unit npc_sel code).
// Optional feature macro: MC_CTRL_MEM_WAIT_EN adds the mem_rdy port and lets
// FETCH, MEM_RD and MEM_WR stall until memory reports ready.
// Illegal encodings retire in DECODE, so they take FETCH + DECODE.

// Fetch-unit next-PC select codes; a project-wide defines.v takes precedence.
`ifndef IFU_SEL_NORM
`define IFU_SEL_NORM 2'd0
`endif
`ifndef IFU_SEL_RELATIVE
`define IFU_SEL_RELATIVE 2'd1
`endif
`ifndef IFU_SEL_IRRELATIVE
`define IFU_SEL_IRRELATIVE 2'd2
`endif
`ifndef IFU_SEL_REGISTER
`define IFU_SEL_REGISTER 2'd3
`endif

module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
`ifdef MC_CTRL_MEM_WAIT_EN
  input  logic        mem_rdy,
`endif
  output logic        ir_wr,
  output logic        pc_wr,
  output logic [1:0]  npc_sel,
  output logic        reg_wr,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic        alu_src,
  output logic [1:0]  ext_op,
  output logic [1:0]  alu_op,
  output logic        mem_wr,
  output logic        illegal,
  output logic [31:0] inst_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;
  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_OR   = 2'd2;
  localparam logic [1:0] DST_RT   = 2'd0;
  localparam logic [1:0] DST_RD   = 2'd1;
  localparam logic [1:0] DST_RA   = 2'd2;
  localparam logic [1:0] WD_ALU   = 2'd0;
  localparam logic [1:0] WD_MEM   = 2'd1;
  localparam logic [1:0] WD_PC4   = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM_RD, S_MEM_WR, S_WB
  } state_t;

  typedef struct packed {
    logic       ir_wr;
    logic       pc_wr;
    logic [1:0] npc_sel;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src;
    logic [1:0] ext_op;
    logic [1:0] alu_op;
    logic       mem_wr;
    logic       illegal;
  } ctrl_t;

  state_t state, state_nxt;
  ctrl_t  ctrl, ctrl_out;
  logic   mem_ok;

  // Instruction class decode from the IR fields.
  logic is_rtype, op_addu, op_subu, op_jr, op_j, op_jal;
  logic op_beq, op_ori, op_lui, op_lw, op_sw, legal;

  assign is_rtype = (opcode == OP_RTYPE);
  assign op_addu  = is_rtype && (funct == FN_ADDU);
  assign op_subu  = is_rtype && (funct == FN_SUBU);
  assign op_jr    = is_rtype && (funct == FN_JR);
  assign op_j     = (opcode == OP_J);
  assign op_jal   = (opcode == OP_JAL);
  assign op_beq   = (opcode == OP_BEQ);
  assign op_ori   = (opcode == OP_ORI);
  assign op_lui   = (opcode == OP_LUI);
  assign op_lw    = (opcode == OP_LW);
  assign op_sw    = (opcode == OP_SW);
  assign legal    = op_addu | op_subu | op_jr | op_j | op_jal | op_beq |
                    op_ori | op_lui | op_lw | op_sw;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign mem_ok = mem_rdy;
`else
  assign mem_ok = 1'b1;
`endif

  // State register; asynchronous reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Next-state and Moore control decode.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path infers a latch.
    state_nxt = state;
    ctrl      = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_wr = 1'b1;
        if (mem_ok) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (!legal) begin
          ctrl.illegal = 1'b1;
          ctrl.pc_wr   = 1'b1;
          ctrl.npc_sel = `IFU_SEL_NORM;
          state_nxt    = S_FETCH;
        end else if (op_j) begin
          ctrl.pc_wr   = 1'b1;
          ctrl.npc_sel = `IFU_SEL_IRRELATIVE;
          state_nxt    = S_FETCH;
        end else if (op_jal) begin
          state_nxt = S_WB;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        state_nxt = S_FETCH;
        if (op_addu || op_subu) begin
          ctrl.alu_op = op_subu ? ALU_SUB : ALU_ADD;
          state_nxt   = S_WB;
        end else if (op_ori || op_lui) begin
          ctrl.alu_src = 1'b1;
          ctrl.ext_op  = op_lui ? EXT_LUI : EXT_ZERO;
          ctrl.alu_op  = ALU_OR;
          state_nxt    = S_WB;
        end else if (op_lw || op_sw) begin
          ctrl.alu_src = 1'b1;
          ctrl.ext_op  = EXT_SIGN;
          ctrl.alu_op  = ALU_ADD;
          state_nxt    = op_lw ? S_MEM_RD : S_MEM_WR;
        end else if (op_beq) begin
          ctrl.alu_op  = ALU_SUB;
          ctrl.pc_wr   = 1'b1;
          ctrl.npc_sel = zero ? `IFU_SEL_RELATIVE : `IFU_SEL_NORM;
        end else if (op_jr) begin
          ctrl.pc_wr   = 1'b1;
          ctrl.npc_sel = `IFU_SEL_REGISTER;
        end
      end
      S_MEM_RD: begin
        // Keep the load address on the bus for the whole read.
        ctrl.alu_src = 1'b1;
        ctrl.ext_op  = EXT_SIGN;
        ctrl.alu_op  = ALU_ADD;
        if (mem_ok) state_nxt = S_WB;
      end
      S_MEM_WR: begin
        ctrl.mem_wr = 1'b1;
        if (mem_ok) begin
          ctrl.pc_wr   = 1'b1;
          ctrl.npc_sel = `IFU_SEL_NORM;
          state_nxt    = S_FETCH;
        end
      end
      S_WB: begin
        ctrl.reg_wr = 1'b1;
        ctrl.pc_wr  = 1'b1;
        state_nxt   = S_FETCH;
        if (op_jal) begin
          ctrl.reg_dst = DST_RA;
          ctrl.wd_sel  = WD_PC4;
          ctrl.npc_sel = `IFU_SEL_IRRELATIVE;
        end else if (op_lw) begin
          ctrl.reg_dst = DST_RT;
          ctrl.wd_sel  = WD_MEM;
          ctrl.npc_sel = `IFU_SEL_NORM;
        end else begin
          ctrl.reg_dst = (op_addu || op_subu) ? DST_RD : DST_RT;
          ctrl.wd_sel  = WD_ALU;
          ctrl.npc_sel = `IFU_SEL_NORM;
        end
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Reset forces every control low, including the FETCH ir_wr.
  assign ctrl_out = reset ? '0 : ctrl;

  assign ir_wr   = ctrl_out.ir_wr;
  assign pc_wr   = ctrl_out.pc_wr;
  assign npc_sel = ctrl_out.npc_sel;
  assign reg_wr  = ctrl_out.reg_wr;
  assign reg_dst = ctrl_out.reg_dst;
  assign wd_sel  = ctrl_out.wd_sel;
  assign alu_src = ctrl_out.alu_src;
  assign ext_op  = ctrl_out.ext_op;
  assign alu_op  = ctrl_out.alu_op;
  assign mem_wr  = ctrl_out.mem_wr;
  assign illegal = ctrl_out.illegal;

  // Retired-instruction counter: one count per PC update, wrapping at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      inst_cnt <= 32'd0;
    else if (pc_wr) inst_cnt <= inst_cnt + 32'd1;
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl.
// A per-instruction reference model expands each instruction class into its
// expected per-cycle control vectors; directed cases come first, then a
// randomized instruction stream. Define MC_CTRL_MEM_WAIT_EN to exercise stalls.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero;
  logic        ir_wr, pc_wr, reg_wr, alu_src, mem_wr, illegal;
  logic [1:0]  npc_sel, reg_dst, wd_sel, ext_op, alu_op;
  logic [31:0] inst_cnt;
`ifdef MC_CTRL_MEM_WAIT_EN
  logic        mem_rdy;
  localparam bit WAIT_MODE = 1'b1;
`else
  localparam bit WAIT_MODE = 1'b0;
`endif

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
`ifdef MC_CTRL_MEM_WAIT_EN
    .mem_rdy(mem_rdy),
`endif
    .ir_wr(ir_wr), .pc_wr(pc_wr), .npc_sel(npc_sel), .reg_wr(reg_wr),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src(alu_src), .ext_op(ext_op),
    .alu_op(alu_op), .mem_wr(mem_wr), .illegal(illegal), .inst_cnt(inst_cnt)
  );

  typedef struct packed {
    logic       ir_wr;
    logic       pc_wr;
    logic [1:0] npc_sel;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src;
    logic [1:0] ext_op;
    logic [1:0] alu_op;
    logic       mem_wr;
    logic       illegal;
  } ctrl_t;

  typedef struct {
    ctrl_t c;
    logic  rdy;
  } step_t;

  typedef enum {I_J, I_JAL, I_BEQ, I_JR, I_ADDU, I_SUBU, I_ORI, I_LUI,
                I_LW, I_SW, I_ILL} inst_e;

  ctrl_t       obs;
  step_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_cnt;

  assign obs = {ir_wr, pc_wr, npc_sel, reg_wr, reg_dst, wd_sel, alu_src,
                ext_op, alu_op, mem_wr, illegal};

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  function automatic inst_e classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: case (fn)
               6'h21:   return I_ADDU;
               6'h23:   return I_SUBU;
               6'h08:   return I_JR;
               default: return I_ILL;
             endcase
      6'h02: return I_J;
      6'h03: return I_JAL;
      6'h04: return I_BEQ;
      6'h0d: return I_ORI;
      6'h0f: return I_LUI;
      6'h23: return I_LW;
      6'h2b: return I_SW;
      default: return I_ILL;
    endcase
  endfunction

  task automatic push(input ctrl_t c, input logic r);
    step_t s;
    s.c = c;
    s.rdy = r;
    exp_q.push_back(s);
  endtask

  // Reference model: expand one instruction into its expected cycle sequence.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fs_in, input int ms_in);
    ctrl_t c, wb;
    inst_e k;
    int fs, ms;
    k  = classify(op, fn);
    fs = WAIT_MODE ? fs_in : 0;
    ms = WAIT_MODE ? ms_in : 0;
    c = '0; c.ir_wr = 1'b1;
    repeat (fs) push(c, 1'b0);
    push(c, 1'b1);
    wb = '0; wb.reg_wr = 1'b1; wb.pc_wr = 1'b1;
    case (k)
      I_ILL: begin c = '0; c.illegal = 1'b1; c.pc_wr = 1'b1; push(c, 1'b1); end
      I_J:   begin c = '0; c.pc_wr = 1'b1; c.npc_sel = 2'd2; push(c, 1'b1); end
      I_JAL: begin
        push('0, 1'b1);
        wb.reg_dst = 2'd2; wb.wd_sel = 2'd2; wb.npc_sel = 2'd2; push(wb, 1'b1);
      end
      I_BEQ: begin
        push('0, 1'b1);
        c = '0; c.alu_op = 2'd1; c.pc_wr = 1'b1; c.npc_sel = z ? 2'd1 : 2'd0;
        push(c, 1'b1);
      end
      I_JR: begin
        push('0, 1'b1);
        c = '0; c.pc_wr = 1'b1; c.npc_sel = 2'd3; push(c, 1'b1);
      end
      I_ADDU, I_SUBU: begin
        push('0, 1'b1);
        c = '0; c.alu_op = (k == I_SUBU) ? 2'd1 : 2'd0; push(c, 1'b1);
        wb.reg_dst = 2'd1; push(wb, 1'b1);
      end
      I_ORI, I_LUI: begin
        push('0, 1'b1);
        c = '0; c.alu_src = 1'b1; c.alu_op = 2'd2;
        c.ext_op = (k == I_LUI) ? 2'd2 : 2'd0; push(c, 1'b1);
        push(wb, 1'b1);
      end
      I_LW: begin
        push('0, 1'b1);
        c = '0; c.alu_src = 1'b1; c.ext_op = 2'd1; push(c, 1'b1);
        repeat (ms) push(c, 1'b0);
        push(c, 1'b1);
        wb.wd_sel = 2'd1; push(wb, 1'b1);
      end
      default: begin // I_SW
        push('0, 1'b1);
        c = '0; c.alu_src = 1'b1; c.ext_op = 2'd1; push(c, 1'b1);
        c = '0; c.mem_wr = 1'b1;
        repeat (ms) push(c, 1'b0);
        c.pc_wr = 1'b1; push(c, 1'b1);
      end
    endcase
  endtask

  // Consume n expected cycles: drive, sample at negedge, advance one clock.
  task automatic run_steps(input int n, input string tag);
    step_t s;
    for (int i = 0; i < n; i++) begin
      s = exp_q.pop_front();
`ifdef MC_CTRL_MEM_WAIT_EN
      mem_rdy = s.rdy;
`endif
      @(negedge clk);
      check({tag, " ctrl"}, 32'(obs), 32'(s.c));
      check({tag, " inst_cnt"}, inst_cnt, model_cnt);
      if (s.c.pc_wr) model_cnt = model_cnt + 32'd1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_inst(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input int fs, input int ms, input string tag);
    opcode = op;
    funct  = fn;
    zero   = z;
    build(op, fn, z, fs, ms);
    run_steps(exp_q.size(), tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] op, fn;
    int sel;
    reset     = 1'b1;
    opcode    = 6'h00;
    funct     = 6'h21;
    zero      = 1'b0;
    model_cnt = 32'd0;
`ifdef MC_CTRL_MEM_WAIT_EN
    mem_rdy   = 1'b1;
`endif

    // Reset held three cycles: every output low, counter cleared.
    repeat (3) begin
      @(negedge clk);
      check("reset ctrl", 32'(obs), 32'd0);
      check("reset inst_cnt", inst_cnt, 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;

    // Directed instruction mix.
    run_inst(6'h00, 6'h21, 1'b0, 0, 0, "addu");
    run_inst(6'h23, 6'h00, 1'b0, 0, 0, "lw");
    run_inst(6'h2b, 6'h00, 1'b0, 0, 0, "sw");
    run_inst(6'h04, 6'h00, 1'b1, 0, 0, "beq_taken");
    run_inst(6'h04, 6'h00, 1'b0, 0, 0, "beq_not_taken");
    run_inst(6'h03, 6'h00, 1'b0, 0, 0, "jal");
    run_inst(6'h3f, 6'h00, 1'b0, 0, 0, "illegal_op");
    run_inst(6'h00, 6'h3f, 1'b0, 0, 0, "illegal_funct");
    run_inst(6'h02, 6'h00, 1'b0, 0, 0, "j");
    run_inst(6'h00, 6'h08, 1'b0, 0, 0, "jr");
    run_inst(6'h00, 6'h23, 1'b0, 0, 0, "subu");
    run_inst(6'h0d, 6'h00, 1'b0, 0, 0, "ori");
    run_inst(6'h0f, 6'h00, 1'b0, 0, 0, "lui");
    if (WAIT_MODE) run_inst(6'h00, 6'h21, 1'b0, 4, 0, "fetch_stall");

    // Reset during a load's MEM_RD aborts it; next cycle is a clean FETCH.
    opcode = 6'h23;
    funct  = 6'h00;
    build(6'h23, 6'h00, 1'b0, 0, 3);
    run_steps(WAIT_MODE ? 4 : 3, "lw_abort");
`ifdef MC_CTRL_MEM_WAIT_EN
    mem_rdy = 1'b0;
`endif
    #2 reset = 1'b1;
    @(negedge clk);
    check("abort ctrl", 32'(obs), 32'd0);
    check("abort inst_cnt", inst_cnt, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    model_cnt = 32'd0;
    run_inst(6'h0d, 6'h00, 1'b0, 0, 0, "after_abort");

    // Randomized instruction stream, including random illegal encodings.
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 11);
      op  = 6'($urandom);
      fn  = 6'($urandom);
      case (sel)
        0:  begin op = 6'h00; fn = 6'h21; end
        1:  begin op = 6'h00; fn = 6'h23; end
        2:  begin op = 6'h00; fn = 6'h08; end
        3:  op = 6'h02;
        4:  op = 6'h03;
        5:  op = 6'h04;
        6:  op = 6'h0d;
        7:  op = 6'h0f;
        8:  op = 6'h23;
        9:  op = 6'h2b;
        10: ;
        default: op = 6'h00;
      endcase
      run_inst(op, fn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
